// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: command sequencer between the SPI byte slave and the
// clk-domain step counter / LED register.
// Optional feature macro: CMD_TIMEOUT_EN (aborts WAIT_DATA after TIMEOUT_CYC cycles).
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | waiting for a command byte
// S_WAIT    | command byte seen, waiting for its data byte
module spi_cmd_ctrl #(
  parameter logic [23:0] PRESCALE     = 24'd12_000_000,
  parameter logic [23:0] TIMEOUT_CYC  = 24'd1_200_000,
  parameter logic [7:0]  RESP_UNKNOWN = 8'hEE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CE0,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic [3:0] led,
  output logic [7:0] count,
  output logic       busy,
  output logic       err
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        pend_led_q, pend_led_d;
  logic        ce0_s1, ce0_s2, ce0_d;
  logic        byte_done;
  logic [23:0] pre_q;
  logic [7:0]  step_q;
  logic        cnt_en_q;
  logic        err_unk_q;
  logic        err_to;
  logic        tmo_hit;
  logic        enter_wait;
  logic        do_led, do_step, do_echo, do_rdcnt, do_rdstat;
  logic        do_en, do_dis, do_clr, do_unk, do_tmo;

  // Two-flop synchroniser plus edge register; presets to 1 so reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce0_s1 <= 1'b1;
      ce0_s2 <= 1'b1;
      ce0_d  <= 1'b1;
    end else begin
      ce0_s1 <= CE0;
      ce0_s2 <= ce0_s1;
      ce0_d  <= ce0_s2;
    end
  end

  assign byte_done = ce0_s2 & ~ce0_d;

`ifdef CMD_TIMEOUT_EN
  logic [23:0] tmr_q;
  logic        err_to_q;

  // WAIT_DATA timeout: down-counter loaded on entry, terminal count at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q    <= '0;
      err_to_q <= 1'b0;
    end else begin
      if (enter_wait)
        tmr_q <= TIMEOUT_CYC - 24'd1;
      else if (state_q == S_WAIT && tmr_q != '0)
        tmr_q <= tmr_q - 24'd1;
      if (do_rdstat)
        err_to_q <= 1'b0;
      else if (do_tmo)
        err_to_q <= 1'b1;
    end
  end

  assign tmo_hit = (tmr_q == '0);
  assign err_to  = err_to_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^{TIMEOUT_CYC, do_tmo, enter_wait};
  assign tmo_hit    = 1'b0;
  assign err_to     = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_led_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_led_q <= pend_led_d;
    end
  end

  // Next-state logic and per-byte action strobes.
  always_comb begin
    state_d    = state_q;
    pend_led_d = pend_led_q;
    enter_wait = 1'b0;
    do_led     = 1'b0;
    do_step    = 1'b0;
    do_echo    = 1'b0;
    do_rdcnt   = 1'b0;
    do_rdstat  = 1'b0;
    do_en      = 1'b0;
    do_dis     = 1'b0;
    do_clr     = 1'b0;
    do_unk     = 1'b0;
    do_tmo     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (byte_done) begin
          case (rx_byte)
            8'h10: begin state_d = S_WAIT; pend_led_d = 1'b1; enter_wait = 1'b1; end
            8'h20: begin state_d = S_WAIT; pend_led_d = 1'b0; enter_wait = 1'b1; end
            8'h30: do_rdcnt  = 1'b1;
            8'h40: do_rdstat = 1'b1;
            8'h50: do_en     = 1'b1;
            8'h51: do_dis    = 1'b1;
            8'h5F: do_clr    = 1'b1;
            default: do_unk  = 1'b1;
          endcase
        end
      end
      S_WAIT: begin
        if (byte_done) begin
          state_d = S_IDLE;
          do_echo = 1'b1;
          do_led  = pend_led_q;
          do_step = ~pend_led_q;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          do_tmo  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter datapath, configuration registers and response byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      count     <= '0;
      step_q    <= 8'd1;
      cnt_en_q  <= 1'b0;
      led       <= '0;
      tx_byte   <= '0;
      err_unk_q <= 1'b0;
    end else begin
      if (cnt_en_q) begin
        if (pre_q == PRESCALE - 24'd1) begin
          pre_q <= '0;
          count <= count + step_q;
        end else begin
          pre_q <= pre_q + 24'd1;
        end
      end
      if (do_clr) begin
        count <= '0;
        pre_q <= '0;
      end
      if (do_en)   cnt_en_q <= 1'b1;
      if (do_dis)  cnt_en_q <= 1'b0;
      if (do_led)  led      <= rx_byte[3:0];
      if (do_step) step_q   <= rx_byte;
      if (do_echo) tx_byte  <= rx_byte;
      if (do_rdcnt) tx_byte <= count;
      if (do_rdstat) begin
        tx_byte   <= {4'b0000, cnt_en_q, busy, err_to, err_unk_q};
        err_unk_q <= 1'b0;
      end
      if (do_unk) begin
        tx_byte   <= RESP_UNKNOWN;
        err_unk_q <= 1'b1;
      end
    end
  end

  assign busy = (state_q == S_WAIT);
  assign err  = err_to | err_unk_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: vector table, directed corner sequences and a
// randomized phase checked against a transaction-level reference model.
module tb_spi_cmd_ctrl;

  localparam int P = 4;
  localparam int T = 64;
`ifdef CMD_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       CE0;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic [3:0] led;
  logic [7:0] count;
  logic       busy;
  logic       err;

  spi_cmd_ctrl #(
    .PRESCALE(24'd4),
    .TIMEOUT_CYC(24'd64),
    .RESP_UNKNOWN(8'hEE)
  ) dut (
    .clk(clk), .rst(rst), .CE0(CE0), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .led(led), .count(count), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  bit       m_wait, m_pend_led;
  bit [3:0] m_led;
  bit [7:0] m_step, m_count, m_tx;
  int       m_pre, m_wc, m_ce_cnt;
  bit       m_en, m_eu, m_et;

  task automatic model_reset();
    m_wait = 0; m_pend_led = 0; m_led = 0; m_step = 8'd1; m_count = 0;
    m_tx = 0; m_pre = 0; m_wc = 0; m_ce_cnt = 0; m_en = 0; m_eu = 0; m_et = 0;
  endtask

  // One clock edge of the command protocol, from the rules of the block.
  task automatic model_edge();
    bit       apply;
    bit [7:0] old_count;
    bit       old_en;
    apply = 0;
    if (m_ce_cnt > 0) begin
      m_ce_cnt--;
      apply = (m_ce_cnt == 0);
    end
    if (rst) begin
      model_reset();
      return;
    end
    old_count = m_count;
    old_en    = m_en;
    if (m_en) begin
      if (m_pre == P - 1) m_count = m_count + m_step;
      m_pre = (m_pre + 1) % P;
    end
    if (m_wait) begin
      m_wc++;
      if (apply) begin
        if (m_pend_led) m_led = rx_byte[3:0];
        else            m_step = rx_byte;
        m_tx   = rx_byte;
        m_wait = 0;
      end else if (TMO && m_wc == T) begin
        m_wait = 0;
        m_et   = 1;
      end
    end else if (apply) begin
      case (rx_byte)
        8'h10: begin m_wait = 1; m_pend_led = 1; m_wc = 0; end
        8'h20: begin m_wait = 1; m_pend_led = 0; m_wc = 0; end
        8'h30: m_tx = old_count;
        8'h40: begin m_tx = {4'b0, old_en, 1'b0, m_et, m_eu}; m_et = 0; m_eu = 0; end
        8'h50: m_en = 1;
        8'h51: m_en = 0;
        8'h5F: begin m_count = 0; m_pre = 0; end
        default: begin m_eu = 1; m_tx = 8'hEE; end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".tx"},    tx_byte,       m_tx);
    chk({tag, ".led"},   {4'b0, led},   {4'b0, m_led});
    chk({tag, ".count"}, count,         m_count);
    chk({tag, ".busy"},  {7'b0, busy},  {7'b0, m_wait});
    chk({tag, ".err"},   {7'b0, err},   {7'b0, (m_eu | m_et)});
  endtask

  // One CE0 window carrying byte b; returns one clk after the decode edge.
  task automatic send_byte(input logic [7:0] b);
    repeat (5) tick();
    CE0 = 1'b0;
    rx_byte = b;
    tick();
    tick();
    CE0 = 1'b1;
    m_ce_cnt = 3;
    repeat (4) tick();
  endtask

  // Same, but the rising edge is placed so decode lands on a counter increment.
  task automatic send_aligned(input logic [7:0] b);
    int guard;
    repeat (5) tick();
    CE0 = 1'b0;
    rx_byte = b;
    tick();
    tick();
    guard = 0;
    while (!(m_en && m_pre == (P - 3 + P) % P) && guard < 10) begin
      tick();
      guard++;
    end
    chk("align_guard", guard[7:0] < 8'd10 ? 8'd1 : 8'd0, 8'd1);
    CE0 = 1'b1;
    m_ce_cnt = 3;
    repeat (4) tick();
  endtask

  typedef struct {
    logic [7:0] b;
    logic [7:0] tx;
    logic [3:0] led;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h10, 8'h00, 4'h0, 1'b1, 1'b0};
    vecs[1] = '{8'h0A, 8'h0A, 4'hA, 1'b0, 1'b0};
    vecs[2] = '{8'h77, 8'hEE, 4'hA, 1'b0, 1'b1};
    vecs[3] = '{8'h40, 8'h01, 4'hA, 1'b0, 1'b0};
    vecs[4] = '{8'h20, 8'h01, 4'hA, 1'b1, 1'b0};
    vecs[5] = '{8'h03, 8'h03, 4'hA, 1'b0, 1'b0};
    vecs[6] = '{8'h30, 8'h00, 4'hA, 1'b0, 1'b0};
    vecs[7] = '{8'h10, 8'h00, 4'hA, 1'b1, 1'b0};
    vecs[8] = '{8'h05, 8'h05, 4'h5, 1'b0, 1'b0};
    vecs[9] = '{8'h40, 8'h00, 4'h5, 1'b0, 1'b0};

    model_reset();
    rst = 1'b1; CE0 = 1'b1; rx_byte = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst.tx", tx_byte, 8'h00);
    chk("rst.led", {4'b0, led}, 8'h00);
    chk("rst.count", count, 8'h00);
    chk("rst.busy", {7'b0, busy}, 8'h00);
    chk("rst.err", {7'b0, err}, 8'h00);

    // vector table: single-byte transactions with fixed expectations
    for (int i = 0; i < 10; i++) begin
      send_byte(vecs[i].b);
      chk($sformatf("vec%0d.tx", i),   tx_byte,         vecs[i].tx);
      chk($sformatf("vec%0d.led", i),  {4'b0, led},     {4'b0, vecs[i].led});
      chk($sformatf("vec%0d.busy", i), {7'b0, busy},    {7'b0, vecs[i].busy});
      chk($sformatf("vec%0d.err", i),  {7'b0, err},     {7'b0, vecs[i].err});
      chk($sformatf("vec%0d.count", i), count,          8'h00);
    end

    // step 3, enable, let it run, read count
    send_byte(8'h20); send_byte(8'h03);
    send_byte(8'h50);
    repeat (40) tick();
    send_byte(8'h30);
    chk_model("rdcount");

    // step 0x80 wraps mod 256
    send_byte(8'h51); send_byte(8'h5F);
    send_byte(8'h20); send_byte(8'h80);
    send_byte(8'h50);
    repeat (3) tick();
    chk("wrap.first", count, 8'h80);
    repeat (4) tick();
    chk("wrap.second", count, 8'h00);
    chk_model("wrap");

    // clear coincident with an increment
    send_aligned(8'h5F);
    chk("clr_on_inc", count, 8'h00);
    chk_model("clr_on_inc");

    // step 0 holds the count while enabled
    send_byte(8'h20); send_byte(8'h00);
    repeat (12) tick();
    chk_model("step0");
    send_byte(8'h51);
    repeat (9) tick();
    chk_model("disabled");

    // WAIT_DATA with a long silence
    send_byte(8'h10);
    repeat (70) tick();
`ifdef CMD_TIMEOUT_EN
    chk("tmo.busy", {7'b0, busy}, 8'h00);
    chk("tmo.err", {7'b0, err}, 8'h01);
    chk_model("tmo");
`else
    chk("notmo.busy", {7'b0, busy}, 8'h01);
    send_byte(8'h05);
    chk("notmo.led", {4'b0, led}, 8'h05);
    chk_model("notmo");
`endif

    // reset in the middle of WAIT_DATA discards the pending write
    send_byte(8'h10);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("midrst.busy", {7'b0, busy}, 8'h00);
    chk("midrst.led", {4'b0, led}, 8'h00);
    send_byte(8'h0F);
    chk("midrst.err", {7'b0, err}, 8'h01);
    chk("midrst.led2", {4'b0, led}, 8'h00);
    chk("midrst.tx", tx_byte, 8'hEE);
    chk_model("midrst");

    // randomized command traffic against the model
    for (int i = 0; i < 150; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 9))
        0: b = 8'h10;
        1: b = 8'h20;
        2: b = 8'h30;
        3: b = 8'h40;
        4: b = 8'h50;
        5: b = 8'h51;
        6: b = 8'h5F;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_byte(b);
      chk_model($sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 15)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
